// File: rtl/score_keeper.sv
// Game scoring stage: turns gameplay event pulses into registered score, lives
// and high-score outputs for the seven-segment display, and runs the IDLE/PLAY/OVER FSM.
module score_keeper #(
  parameter int unsigned MAX_SCORE   = 9999,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned MAX_COMBO   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_start,
  input  logic        brick_hit,
  input  logic [2:0]  brick_row,
  input  logic        paddle_hit,
  input  logic        ball_lost,
  output logic [13:0] current_score,
  output logic [13:0] high_score,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        playing,
  output logic        new_high
);

  localparam int CW = $clog2(MAX_COMBO + 1);
  localparam logic [13:0]   MAX_S   = 14'(MAX_SCORE);
  localparam logic [1:0]    LIVES_S = 2'(START_LIVES);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_COMBO);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] combo, combo_next;
  logic [13:0]   score_next, high_next;
  logic [1:0]    lives_next;
  logic          over_first, over_first_next;
  logic          new_high_next;
  logic [3:0]    base;
  logic [14:0]   points, sum;

  // Brick value; combo never exceeds MAX_COMBO so no extra clamp is needed.
  always_comb begin
    base   = 4'd8 - {1'b0, brick_row};
    points = 15'(base) * 15'(combo);
    sum    = {1'b0, current_score} + points;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next      = state;
    score_next      = current_score;
    high_next       = high_score;
    lives_next      = lives;
    combo_next      = combo;
    new_high_next   = 1'b0;
    over_first_next = 1'b0;

    // The finished game's score is compared in the first OVER cycle, even if a new game starts then.
    if (over_first && (current_score > high_score)) begin
      high_next     = current_score;
      new_high_next = 1'b1;
    end else begin
      high_next     = high_score;
      new_high_next = 1'b0;
    end

    case (state)
      IDLE, OVER: begin
        if (game_start) begin
          state_next = PLAY;
          score_next = 14'd0;
          lives_next = LIVES_S;
          combo_next = ONE_C;
        end else begin
          state_next = state;
        end
      end
      PLAY: begin
        if (game_start) begin
          score_next = 14'd0;
          lives_next = LIVES_S;
          combo_next = ONE_C;
        end else begin
          if (brick_hit) begin
            score_next = (sum > {1'b0, MAX_S}) ? MAX_S : sum[13:0];
          end else begin
            score_next = current_score;
          end
          if (ball_lost || paddle_hit) begin
            combo_next = ONE_C;
          end else if (brick_hit && (combo < MAX_C)) begin
            combo_next = combo + ONE_C;
          end else begin
            combo_next = combo;
          end
          if (ball_lost && (lives <= 2'd1)) begin
            lives_next      = 2'd0;
            state_next      = OVER;
            over_first_next = 1'b1;
          end else if (ball_lost) begin
            lives_next = lives - 2'd1;
          end else begin
            lives_next = lives;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; game_over/playing decode the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      current_score <= 14'd0;
      high_score    <= 14'd0;
      lives         <= 2'd0;
      combo         <= ONE_C;
      over_first    <= 1'b0;
      new_high      <= 1'b0;
      game_over     <= 1'b0;
      playing       <= 1'b0;
    end else begin
      state         <= state_next;
      current_score <= score_next;
      high_score    <= high_next;
      lives         <= lives_next;
      combo         <= combo_next;
      over_first    <= over_first_next;
      new_high      <= new_high_next;
      game_over     <= (state_next == OVER);
      playing       <= (state_next == PLAY);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus random events,
// all compared against an arithmetic game model.
module tb_score_keeper;

  localparam int MAXS  = 9999;
  localparam int START = 3;
  localparam int MAXC  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_start = 1'b0, brick_hit = 1'b0, paddle_hit = 1'b0, ball_lost = 1'b0;
  logic [2:0]  brick_row = 3'd0;
  logic [13:0] current_score, high_score;
  logic [1:0]  lives;
  logic        game_over, playing, new_high;

  int total = 0;
  int bad   = 0;

  // Model of the game rules.
  int m_score, m_high, m_lives, m_combo;
  bit m_play, m_over, m_pend, m_nh;

  score_keeper #(.MAX_SCORE(MAXS), .START_LIVES(START), .MAX_COMBO(MAXC)) dut (
    .clk(clk), .rst(rst), .game_start(game_start), .brick_hit(brick_hit),
    .brick_row(brick_row), .paddle_hit(paddle_hit), .ball_lost(ball_lost),
    .current_score(current_score), .high_score(high_score), .lives(lives),
    .game_over(game_over), .playing(playing), .new_high(new_high)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_high = 0; m_lives = 0; m_combo = 1;
    m_play = 0; m_over = 0; m_pend = 0; m_nh = 0;
  endtask

  task automatic model_step(input bit s, input bit b, input int r, input bit p, input bit l);
    int pts;
    m_nh = 0;
    if (m_pend && m_score > m_high) begin
      m_high = m_score;
      m_nh = 1;
    end
    m_pend = 0;
    if (s) begin
      m_score = 0; m_lives = START; m_combo = 1; m_play = 1; m_over = 0;
    end else if (m_play) begin
      if (b) begin
        pts = (8 - r) * ((m_combo < MAXC) ? m_combo : MAXC);
        m_score = (m_score + pts > MAXS) ? MAXS : m_score + pts;
      end
      if (l) begin
        m_combo = 1;
        m_lives = m_lives - 1;
        if (m_lives == 0) begin
          m_play = 0; m_over = 1; m_pend = 1;
        end
      end else if (p) begin
        m_combo = 1;
      end else if (b) begin
        m_combo = (m_combo + 1 > MAXC) ? MAXC : m_combo + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("score", int'(current_score), m_score);
    chk("high", int'(high_score), m_high);
    chk("lives", int'(lives), m_lives);
    chk("game_over", int'(game_over), int'(m_over));
    chk("playing", int'(playing), int'(m_play));
    chk("new_high", int'(new_high), int'(m_nh));
  endtask

  task automatic cyc(input bit s, input bit b, input int r, input bit p, input bit l);
    @(negedge clk);
    game_start = s; brick_hit = b; brick_row = r[2:0]; paddle_hit = p; ball_lost = l;
    @(posedge clk);
    model_step(s, b, r, p, l);
    #1;
    game_start = 1'b0; brick_hit = 1'b0; paddle_hit = 1'b0; ball_lost = 1'b0;
    check_all();
  endtask

  task automatic idle(); cyc(1'b0, 1'b0, 0, 1'b0, 1'b0); endtask
  task automatic hit(input int r); cyc(1'b0, 1'b1, r, 1'b0, 1'b0); endtask
  task automatic lose(); cyc(1'b0, 1'b0, 0, 1'b0, 1'b1); endtask
  task automatic start(); cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); endtask

  // Start, drop to one life, score via row-0 x5 then extras, then lose the last ball.
  task automatic play_game(input bit to_119);
    start(); lose(); lose();
    for (int i = 0; i < 5; i++) hit(0);
    hit(7);
    if (to_119) begin
      cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
      hit(5);
      chk("score_119", int'(current_score), 119);
    end else begin
      hit(7);
      chk("score_120", int'(current_score), 120);
    end
    chk("lives_one", int'(lives), 1);
    lose();
    chk("over_flag", int'(game_over), 1);
    chk("over_lives", int'(lives), 0);
  endtask

  initial begin
    bit s, b, p, l;
    int guard;
    model_reset();
    #1;
    chk("rst_score", int'(current_score), 0);
    chk("rst_high", int'(high_score), 0);
    chk("rst_playing", int'(playing), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();

    // Three top-row hits.
    start();
    hit(0); chk("t1_8", int'(current_score), 8);
    hit(0); chk("t1_24", int'(current_score), 24);
    hit(0); chk("t1_48", int'(current_score), 48);
    chk("t1_lives", int'(lives), 3);
    chk("t1_playing", int'(playing), 1);

    // Combo cap and paddle reset.
    start();
    hit(7); hit(7); hit(7); hit(7); hit(7);
    chk("t2_14", int'(current_score), 14);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
    hit(7); chk("t2_15", int'(current_score), 15);

    // Saturation.
    start();
    guard = 0;
    while (m_score < 9999 && guard < 400) begin
      hit(0);
      guard++;
    end
    chk("sat_9999", int'(current_score), 9999);
    hit(0); chk("sat_hold", int'(current_score), 9999);

    // Game over and high score at 120, then a tie, then 119.
    play_game(1'b0);
    chk("nh_early", int'(new_high), 0);
    idle(); chk("hs_120", int'(high_score), 120); chk("nh_pulse", int'(new_high), 1);
    idle(); chk("nh_drop", int'(new_high), 0);
    hit(0); chk("over_ignore", int'(current_score), 120);
    play_game(1'b0);
    idle(); chk("tie_nh", int'(new_high), 0); chk("tie_hs", int'(high_score), 120);
    play_game(1'b1);
    idle(); chk("lo_nh", int'(new_high), 0); chk("lo_hs", int'(high_score), 120);

    // Simultaneous events.
    start();
    hit(0);
    cyc(1'b0, 1'b1, 4, 1'b0, 1'b1);
    chk("sim_lost_score", int'(current_score), 16);
    chk("sim_lost_lives", int'(lives), 2);
    hit(7); chk("sim_combo1", int'(current_score), 17);
    cyc(1'b1, 1'b1, 0, 1'b0, 1'b0);
    chk("sim_start", int'(current_score), 0);

    // Random events.
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 99) < 2) && !m_pend;
      b = $urandom_range(0, 99) < 40;
      p = $urandom_range(0, 99) < 10;
      l = $urandom_range(0, 99) < 5;
      cyc(s, b, $urandom_range(0, 7), p, l);
    end

    // Asynchronous reset mid-game.
    start();
    repeat (10) hit(0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_score", int'(current_score), 0);
    chk("arst_high", int'(high_score), 0);
    chk("arst_lives", int'(lives), 0);
    chk("arst_playing", int'(playing), 0);
    chk("arst_over", int'(game_over), 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    hit(0); chk("arst_idle_ignore", int'(current_score), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
